// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the
// operation (read/write) latched at grant time.
package mem_port_arbiter_pkg;

  // State encoding kept as plain constants so legacy blocks can compare raw codes.
  typedef logic [1:0] arb_state_enum;
  localparam arb_state_enum ARB_IDLE = 2'd0;
  localparam arb_state_enum ARB_REQ  = 2'd1;
  localparam arb_state_enum ARB_RESP = 2'd2;

  typedef enum logic {
    ARB_RD = 1'b0,
    ARB_WR = 1'b1
  } arb_op_enum;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Mem_ift-style read/write request/reply bundle. N_CH is the number of
// channels carried (1 for the downstream memory port). The master modport is
// the side that issues requests; the slave modport answers them.
interface mem_port_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic [N_CH-1:0]              r_request_valid;
  logic [N_CH-1:0][ADDR_W-1:0]  r_request_raddr;
  logic [N_CH-1:0]              r_request_ready;
  logic [N_CH-1:0]              r_reply_valid;
  logic [N_CH-1:0]              r_reply_ready;
  logic [DATA_W-1:0]            r_reply_rdata;

  logic [N_CH-1:0]              w_request_valid;
  logic [N_CH-1:0][ADDR_W-1:0]  w_request_waddr;
  logic [N_CH-1:0][DATA_W-1:0]  w_request_wdata;
  logic [N_CH-1:0][MASK_W-1:0]  w_request_wmask;
  logic [N_CH-1:0]              w_request_ready;
  logic [N_CH-1:0]              w_reply_valid;
  logic [N_CH-1:0]              w_reply_ready;

  modport master (
    output r_request_valid, r_request_raddr, r_reply_ready,
    input  r_request_ready, r_reply_valid, r_reply_rdata,
    output w_request_valid, w_request_waddr, w_request_wdata, w_request_wmask, w_reply_ready,
    input  w_request_ready, w_reply_valid
  );

  modport slave (
    input  r_request_valid, r_request_raddr, r_reply_ready,
    output r_request_ready, r_reply_valid, r_reply_rdata,
    input  w_request_valid, w_request_waddr, w_request_wdata, w_request_wmask, w_reply_ready,
    output w_request_ready, w_reply_valid
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational rotating picker: scans the pending vector starting at
// start_idx and wrapping around, returning the first pending channel.
module rr_picker #(
  parameter  int N_CH = 2,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] pending,
  input  logic [ID_W-1:0] start_idx,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  // First pending channel at or after start_idx, modulo N_CH.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(start_idx) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!any && pending[idx]) begin
        any    = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter merging master channels onto one memory port, one
// transaction in flight at a time. Define MEM_ARB_RR_EN for round-robin
// selection; otherwise fixed priority with channel 0 highest.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int N_CH   = 2,
  parameter  int ADDR_W = 64,
  parameter  int DATA_W = 64,
  localparam int MASK_W = DATA_W / 8,
  localparam int ID_W   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  m,
  mem_port_arbiter_if.master s,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id
);

  arb_state_enum   state;
  arb_op_enum      op;
  logic [ID_W-1:0] grant;
  logic [N_CH-1:0] grant_oh;
  logic [N_CH-1:0] pending;
  logic [ID_W-1:0] start_idx;
  logic [ID_W-1:0] winner;
  logic            any_pending;
  logic            req_hs;
  logic            reply_hs;

  logic [ADDR_W-1:0] sel_raddr;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_wmask;

  assign pending  = m.r_request_valid | m.w_request_valid;
  assign grant_oh = {{(N_CH-1){1'b0}}, 1'b1} << grant;
  assign req_hs   = (s.r_request_valid[0] & s.r_request_ready[0]) |
                    (s.w_request_valid[0] & s.w_request_ready[0]);
  assign reply_hs = (s.r_reply_valid[0] & s.r_reply_ready[0]) |
                    (s.w_reply_valid[0] & s.w_reply_ready[0]);

`ifdef MEM_ARB_RR_EN
  logic [ID_W-1:0] ptr;
  assign start_idx = ptr;

  // Rotate the search start to just past the channel that completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == ARB_RESP && reply_hs) begin
      ptr <= (grant == ID_W'(N_CH - 1)) ? '0 : grant + 1'b1;
    end
  end
`else
  assign start_idx = '0;
`endif

  rr_picker #(.N_CH(N_CH)) u_picker (
    .pending   (pending),
    .start_idx (start_idx),
    .winner    (winner),
    .any       (any_pending)
  );

  // Grant FSM: pick in IDLE, hold the grant through request and reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      op    <= ARB_RD;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_pending) begin
            grant <= winner;
            op    <= m.r_request_valid[winner] ? ARB_RD : ARB_WR;
            state <= ARB_REQ;
          end
        end
        ARB_REQ:  if (req_hs)   state <= ARB_RESP;
        ARB_RESP: if (reply_hs) state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  // Request fields follow the granted master every cycle.
  assign sel_raddr = m.r_request_raddr[grant];
  assign sel_waddr = m.w_request_waddr[grant];
  assign sel_wdata = m.w_request_wdata[grant];
  assign sel_wmask = m.w_request_wmask[grant];

  assign s.r_request_raddr = sel_raddr;
  assign s.w_request_waddr = sel_waddr;
  assign s.w_request_wdata = sel_wdata;
  assign s.w_request_wmask = sel_wmask;
  assign m.r_reply_rdata   = s.r_reply_rdata;

  assign busy     = (state != ARB_IDLE);
  assign grant_id = grant;

  // Handshake routing: only the granted channel sees ready/valid, only for its op.
  always_comb begin
    s.r_request_valid = 1'b0;
    s.w_request_valid = 1'b0;
    s.r_reply_ready   = 1'b0;
    s.w_reply_ready   = 1'b0;
    m.r_request_ready = '0;
    m.w_request_ready = '0;
    m.r_reply_valid   = '0;
    m.w_reply_valid   = '0;
    case (state)
      ARB_REQ: begin
        s.r_request_valid = (op == ARB_RD);
        s.w_request_valid = (op == ARB_WR);
        m.r_request_ready = (op == ARB_RD && s.r_request_ready[0]) ? grant_oh : '0;
        m.w_request_ready = (op == ARB_WR && s.w_request_ready[0]) ? grant_oh : '0;
      end
      ARB_RESP: begin
        s.r_reply_ready = (op == ARB_RD) & m.r_reply_ready[grant];
        s.w_reply_ready = (op == ARB_WR) & m.w_reply_ready[grant];
        m.r_reply_valid = (op == ARB_RD && s.r_reply_valid[0]) ? grant_oh : '0;
        m.w_reply_valid = (op == ARB_WR && s.w_reply_valid[0]) ? grant_oh : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with N_CH=2. The bench plays both the
// masters and the memory slave; expectations follow the build selected by
// MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic grant_id;

  int checkCount = 0;
  int passCount  = 0;

  mem_port_arbiter_if #(.N_CH(2), .ADDR_W(64), .DATA_W(64)) m ();
  mem_port_arbiter_if #(.N_CH(1), .ADDR_W(64), .DATA_W(64)) s ();

  mem_port_arbiter #(.N_CH(2), .ADDR_W(64), .DATA_W(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .m        (m),
    .s        (s),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [1:0] oneHot(input int ch);
    logic [1:0] one;
    one = 2'b01;
    return one << ch;
  endfunction

  task automatic applyStimulus(input int ch, input bit rdv, input logic [63:0] raddr,
                               input bit wrv, input logic [63:0] waddr,
                               input logic [63:0] wdata, input logic [7:0] wmask);
    m.r_request_valid[ch] = rdv;
    m.r_request_raddr[ch] = raddr;
    m.w_request_valid[ch] = wrv;
    m.w_request_waddr[ch] = waddr;
    m.w_request_wdata[ch] = wdata;
    m.w_request_wmask[ch] = wmask;
  endtask

  // Reply phase: enter RESP, slave answers at once, then back in IDLE.
  task automatic respPhase(input int ch, input bit isWr, input logic [63:0] data, input bit dropAfter);
    tick();
    if (dropAfter) begin
      if (isWr) m.w_request_valid[ch] = 1'b0;
      else      m.r_request_valid[ch] = 1'b0;
    end
    if (isWr) begin
      s.w_reply_valid = 1'b1;
      m.w_reply_ready = oneHot(ch);
    end else begin
      s.r_reply_valid = 1'b1;
      s.r_reply_rdata = data;
      m.r_reply_ready = oneHot(ch);
    end
    settle();
    checkOutput("resp_busy", busy, 1);
    checkOutput("resp_m_r_reply_valid", m.r_reply_valid, isWr ? 2'b00 : oneHot(ch));
    checkOutput("resp_m_w_reply_valid", m.w_reply_valid, isWr ? oneHot(ch) : 2'b00);
    checkOutput("resp_s_reply_ready", {s.r_reply_ready, s.w_reply_ready}, isWr ? 2'b01 : 2'b10);
    checkOutput("resp_m_req_ready", {m.r_request_ready, m.w_request_ready}, 0);
    if (!isWr) checkOutput("resp_rdata", m.r_reply_rdata, data);
    tick();
    s.r_reply_valid = 1'b0;
    s.w_reply_valid = 1'b0;
    m.r_reply_ready = 2'b00;
    m.w_reply_ready = 2'b00;
    settle();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_s_req_valid", {s.r_request_valid, s.w_request_valid}, 0);
    checkOutput("idle_m_reply_valid", {m.r_reply_valid, m.w_reply_valid}, 0);
  endtask

  // Full transaction, called in an IDLE cycle with the request already visible.
  task automatic runTxn(input int ch, input bit isWr, input logic [63:0] addr,
                        input logic [63:0] data, input logic [7:0] mask, input bit dropAfter);
    tick();
    checkOutput("req_busy", busy, 1);
    checkOutput("req_grant_id", grant_id, ch);
    checkOutput("req_s_r_valid", s.r_request_valid, !isWr);
    checkOutput("req_s_w_valid", s.w_request_valid, isWr);
    checkOutput("req_s_reply_ready", {s.r_reply_ready, s.w_reply_ready}, 0);
    if (isWr) begin
      checkOutput("req_s_waddr", s.w_request_waddr, addr);
      checkOutput("req_s_wdata", s.w_request_wdata, data);
      checkOutput("req_s_wmask", s.w_request_wmask, mask);
      checkOutput("req_m_w_ready", m.w_request_ready, oneHot(ch));
      checkOutput("req_m_r_ready", m.r_request_ready, 0);
    end else begin
      checkOutput("req_s_raddr", s.r_request_raddr, addr);
      checkOutput("req_m_r_ready", m.r_request_ready, oneHot(ch));
      checkOutput("req_m_w_ready", m.w_request_ready, 0);
    end
    respPhase(ch, isWr, data, dropAfter);
  endtask

  // A master whose request was not accepted must keep valid high.
  logic [1:0] waitR = 2'b00;
  logic [1:0] waitW = 2'b00;
  always @(negedge clk) begin
    if (rst) begin
      waitR = 2'b00;
      waitW = 2'b00;
    end else begin
      if (waitR != 2'b00 || waitW != 2'b00) begin
        checkCount++;
        assert (((waitR & ~m.r_request_valid) | (waitW & ~m.w_request_valid)) == 2'b00) passCount++;
        else $error("[TB] FAIL hold_valid: observed r=%b w=%b expected held r=%b w=%b",
                    m.r_request_valid, m.w_request_valid, waitR, waitW);
      end
      waitR = m.r_request_valid & ~m.r_request_ready;
      waitW = m.w_request_valid & ~m.w_request_ready;
    end
  end

  int expW;
  int other;

  initial begin
    rst = 1'b1;
    m.r_request_valid = 2'b00;
    m.w_request_valid = 2'b00;
    m.r_request_raddr = '0;
    m.w_request_waddr = '0;
    m.w_request_wdata = '0;
    m.w_request_wmask = '0;
    m.r_reply_ready   = 2'b00;
    m.w_reply_ready   = 2'b00;
    s.r_request_ready = 1'b1;
    s.w_request_ready = 1'b1;
    s.r_reply_valid   = 1'b0;
    s.w_reply_valid   = 1'b0;
    s.r_reply_rdata   = '0;

    // Reset holds the arbiter idle even with a request present.
    applyStimulus(0, 1, 64'h40, 0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_handshakes", {m.r_request_ready, m.r_reply_valid, m.w_request_ready,
                m.w_reply_valid, s.r_request_valid, s.w_request_valid,
                s.r_reply_ready, s.w_reply_ready}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single read on ch1");
    applyStimulus(1, 1, 64'h80, 0, 0, 0, 0);
    settle();
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_idle_s_r_valid", s.r_request_valid, 0);
    runTxn(1, 0, 64'h80, 64'hDEADBEEF, 0, 1);

    $display("[TB] simultaneous reads on ch0 and ch1");
    applyStimulus(0, 1, 64'h100, 0, 0, 0, 0);
    applyStimulus(1, 1, 64'h200, 0, 0, 0, 0);
    settle();
`ifdef MEM_ARB_RR_EN
    runTxn(0, 0, 64'h100, 64'hA0, 0, 0);
    runTxn(1, 0, 64'h200, 64'hA1, 0, 0);
    runTxn(0, 0, 64'h100, 64'hA2, 0, 1);
    runTxn(1, 0, 64'h200, 64'hA3, 0, 1);
`else
    runTxn(0, 0, 64'h100, 64'hA0, 0, 0);
    runTxn(0, 0, 64'h100, 64'hA1, 0, 0);
    runTxn(0, 0, 64'h100, 64'hA2, 0, 1);
    runTxn(1, 0, 64'h200, 64'hA3, 0, 1);
`endif

    $display("[TB] read and write on ch0");
    applyStimulus(0, 1, 64'h10, 1, 64'h18, 64'h1122334455667788, 8'hFF);
    settle();
    runTxn(0, 0, 64'h10, 64'hCAFEF00D, 0, 1);
    runTxn(0, 1, 64'h18, 64'h1122334455667788, 8'hFF, 1);

    $display("[TB] slave backpressure");
`ifdef MEM_ARB_RR_EN
    expW = 1;
`else
    expW = 0;
`endif
    other = 1 - expW;
    applyStimulus(0, 1, 64'h400, 0, 0, 0, 0);
    applyStimulus(1, 1, 64'h500, 0, 0, 0, 0);
    s.r_request_ready = 1'b0;
    settle();
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_grant_id", grant_id, expW);
      checkOutput("bp_s_r_valid", s.r_request_valid, 1);
      checkOutput("bp_s_raddr", s.r_request_raddr, (expW == 1) ? 64'h500 : 64'h400);
      checkOutput("bp_m_r_ready", m.r_request_ready, 0);
      tick();
    end
    s.r_request_ready = 1'b1;
    settle();
    checkOutput("bp_release_ready", m.r_request_ready, oneHot(expW));
    respPhase(expW, 0, 64'h5555, 1);
    runTxn(other, 0, (other == 1) ? 64'h500 : 64'h400, 64'h6666, 0, 1);

    $display("[TB] reset during reply");
    applyStimulus(1, 1, 64'h80, 0, 0, 0, 0);
    settle();
    tick();
    checkOutput("rr_req_grant", grant_id, 1);
    tick();
    s.r_reply_valid = 1'b1;
    s.r_reply_rdata = 64'h77;
    m.r_reply_ready = 2'b10;
    settle();
    checkOutput("rr_resp_valid", m.r_reply_valid, 2'b10);
    rst = 1'b1;
    applyStimulus(0, 1, 64'h300, 0, 0, 0, 0);
    tick();
    s.r_reply_valid = 1'b0;
    m.r_reply_ready = 2'b00;
    rst = 1'b0;
    settle();
    checkOutput("rr_after_busy", busy, 0);
    checkOutput("rr_after_grant_id", grant_id, 0);
    checkOutput("rr_after_valids", {m.r_reply_valid, m.w_reply_valid, m.r_request_ready,
                s.r_request_valid, s.w_request_valid}, 0);
    runTxn(0, 0, 64'h300, 64'h33, 0, 1);
    runTxn(1, 0, 64'h80, 64'h44, 0, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-channel arbiter that merges several `Mem_ift`-style master channels onto one downstream memory port. It is the generalised successor of the core's two-way imem/dmem sequencing FSM. Each grant carries exactly one read or write transaction through request and reply, and only one transaction is outstanding at a time. Channel selection is round-robin or fixed-priority depending on configuration; it sits between core/fetch/DMA clients and the shared memory model.

## Interface
Parameters:
- `N_CH`, 2: number of master channels (≥2).
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width; mask width `MASK_W = DATA_W/8` is derived.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `m_r_request_valid` in N_CH: per-channel read request.
- `m_r_request_raddr` in N_CH×ADDR_W: per-channel read address.
- `m_r_request_ready` out N_CH: read request accepted.
- `m_r_reply_valid` out N_CH: read data valid.
- `m_r_reply_ready` in N_CH: master accepts read data.
- `m_r_reply_rdata` out DATA_W: read data, broadcast to all channels.
- `m_w_request_valid` in N_CH: per-channel write request.
- `m_w_request_waddr` in N_CH×ADDR_W: per-channel write address.
- `m_w_request_wdata` in N_CH×DATA_W: per-channel write data.
- `m_w_request_wmask` in N_CH×MASK_W: per-channel write mask.
- `m_w_request_ready` out N_CH: write request accepted.
- `m_w_reply_valid` out N_CH: write done.
- `m_w_reply_ready` in N_CH: master accepts write done.
- `s_*` (same signal set, single channel, opposite directions): downstream memory port.
- `busy` out 1: a transaction is granted.
- `grant_id` out $clog2(N_CH): granted channel, valid while `busy`.

## Operation
- FSM states:
  - `ARB_IDLE`: evaluate pending channels; any pending → latch the winning channel, latch op (read/write) → `ARB_REQ`.
  - `ARB_REQ`: drive `s_r_request_valid` or `s_w_request_valid` with the granted channel's fields.
    - Route `s_*_request_ready` only to the granted channel.
    - Request handshake (valid&ready) → `ARB_RESP`.
  - `ARB_RESP`: route `s_*_reply_valid` to the granted channel only, and the granted channel's `*_reply_ready` to `s_*_reply_ready`.
    - Reply handshake → `ARB_IDLE` and update the priority pointer.
- Pending for a channel is `m_r_request_valid | m_w_request_valid`.
- If one channel asserts both read and write valid, read is served first and write stays pending.
- Non-granted channels see all ready/valid outputs at 0 and must hold their requests stable.
- Request fields are muxed from the master combinationally each cycle. Masters must hold fields stable while valid and not yet accepted.
- `m_r_reply_rdata` = `s_r_reply_rdata` unconditionally.

## Timing
- Reset values:
  - State `ARB_IDLE`, pointer 0.
  - `busy`=0, `grant_id`=0.
  - All `*_valid`/`*_ready` outputs 0.
- Grant latency: a request first visible in `ARB_IDLE` at cycle t gives `s_*_request_valid`=1 at t+1.
- With a slave that is ready immediately and replies in 1 cycle: request handshake at t+1, reply handshake at t+2, `ARB_IDLE` at t+3.
  - Minimum 3 cycles per transaction.
- Next grant is decided at earliest in the cycle after the reply handshake. There is no back-to-back bypass.
- `busy`=1 exactly in `ARB_REQ` and `ARB_RESP`.
- A master dropping valid before acceptance is illegal; the bench asserts on it.
- A request arriving in the same cycle as a grant decision is not considered until the next `ARB_IDLE`.
- `rst` mid-transaction: the FSM returns to `ARB_IDLE` on the next edge and the in-flight reply is discarded. The slave is assumed reset by the same `rst`.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin. Search starts at the pointer; after completion the pointer = (granted channel + 1) mod `N_CH`.
- Undefined:
  - Fixed priority, channel 0 highest.
  - Pointer register is removed.

## Structure
- Shared package (`PipelinePack` or a new `ArbPack`) holds:
  - `arb_state_enum {ARB_IDLE, ARB_REQ, ARB_RESP}`.
  - `arb_op_enum {ARB_RD, ARB_WR}`.
- One combinational sub-module `rr_picker` (params `N_CH`). Inputs: pending vector and start index. Outputs: winner index and `any`.
  - The fixed-priority build ties the start index to 0.

## Test plan
- Single read, N_CH=2: ch1 reads 0x80 while ch0 is idle; slave returns 0xDEADBEEF → only `m_r_reply_valid[1]` pulses; `grant_id`=1; 3 cycles from request to IDLE.
- Simultaneous requests, RR build: ch0 and ch1 hold reads continuously → grants alternate 0,1,0,1 over 4 transactions.
- Same stimulus, fixed build → ch0 is granted repeatedly while it stays pending; ch1 is served only after ch0 deasserts.
- Read+write on one channel: ch0 asserts read 0x10 and write 0x18 (mask 0xFF) → read completes first, then the write, with `wmask` 0xFF on `s_w`.
- Slave backpressure: `s_r_request_ready` held low for 5 cycles → the FSM stays in `ARB_REQ`, `m_r_request_ready` stays 0, and no other channel is granted.
- Reset during `ARB_RESP` → next cycle `busy`=0 and all valid outputs 0; the pending request is re-arbitrated afterwards with pointer 0.
